shift_counter: RTL and testbench
================================

# shift_counter

Parametrised shift-register counter generalising the fixed 4-bit Johnson counter.
- Runtime-selectable direction, clock enable, parallel load, a decoded binary phase and a wrap pulse.
- Compile-time choice of ring or Johnson (twisted-ring) mode.
- Optional self-correction of illegal states.

Used as a low-glitch sequencer and phase generator wherever the design needs a decoded multi-phase timing source.

## Interface

Clocking and reset:
- One clock; reset is asynchronous and active-high.
- Clock port `clk`, reset port `clear`.

Parameters:
- `WIDTH`, 4: register width; legal range ≥ 2.
- `MODE`, 1: 0 = ring, 1 = Johnson.
- `SELF_CORRECT`, 1: 1 = an illegal state is replaced by the reset state on the next enabled step.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `clear` in 1: asynchronous, active-high reset.
- `en` in 1: step enable.
- `dir` in 1: 0 = up (shift toward MSB), 1 = down (shift toward LSB).
- `load` in 1: synchronous parallel load.
- `load_val` in WIDTH: value loaded when `load` = 1.
- `q` out WIDTH: counter state.
- `phase` out PW: binary phase index of `q`, where PW = $clog2(2*WIDTH).
- `wrap` out 1: registered one-cycle pulse on sequence wrap.
- `illegal` out 1: current `q` is not a legal state for `MODE`.

## Operation

Reset values:
- Ring: `q` = 1 (bit 0 set).
- Johnson: `q` = 0.
- `wrap` = 0 in both modes.
- `phase` = 0 and `illegal` = 0, both follow from `q`.

Period and last phase:
- P = WIDTH (ring) or 2*WIDTH (Johnson).
- LAST = P-1.

Priority per rising edge: `load` > `en` > hold.
- `load` = 1: `q` <= `load_val`. Any value is accepted, including illegal ones. `wrap` <= 0.
- `en` = 1, `illegal` = 1, `SELF_CORRECT` = 1: `q` <= reset value regardless of `dir`; `wrap` <= 0.
- `en` = 1, otherwise: shift as listed below.
- `en` = 0: `q` holds; `wrap` <= 0.

Shift rules:
- Johnson up: `q` <= {q[W-2:0], ~q[W-1]}.
- Johnson down: `q` <= {~q[0], q[W-1:1]}.
- Ring up: `q` <= {q[W-2:0], q[W-1]}.
- Ring down: `q` <= {q[0], q[W-1:1]}.
- With `SELF_CORRECT` = 0, illegal patterns shift by the same rules.

Legal states and phase decode (combinational from `q`):
- Ring: exactly one bit set. `phase` = index of the set bit.
- Johnson: contiguous ones anchored at bit 0 (including all-zero), or contiguous ones anchored at bit W-1. With n = popcount(q):
  - `phase` = n if q[W-1] = 0;
  - `phase` = 2W−n otherwise.
- Illegal state: `phase` = 0 and `illegal` = 1.

Wrap rules:
- `wrap` <= 1 on an enabled shift of a legal state from LAST to 0 (up) or from 0 to LAST (down).
- `dir` may change on any cycle. The step taken uses the `dir` value sampled at that edge.

## Timing

- `q`, `wrap`: registered, one edge after the controlling inputs are sampled.
- `phase`, `illegal`: combinational from `q`, zero latency. `wrap` is high in the same cycle `q` shows the post-wrap state.
- `clear` asserted mid-count: `q` and `wrap` take their reset values immediately, without a clock edge. On the first edge after deassertion, normal priority applies.
- Self-correction takes exactly one enabled edge. It never takes effect while `en` = 0.

## Structure

Shared package `shift_counter_pkg`:
- constants `MODE_RING` = 0 and `MODE_JOHNSON` = 1;
- function `sc_period(width, mode)` returning P.

Sub-module `shift_phase_decode`:
- purely combinational;
- parameters `WIDTH` and `MODE`;
- input `q`; outputs `phase` and `illegal`.

Top level `shift_counter` holds the register, the next-state mux and the `wrap` flop.

## Test plan

All scenarios use W = 4.
- **Johnson up:** reset, `en` = 1, `dir` = 0 for 8 cycles → `q` = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; `phase` = 1..7, 0; `wrap` = 1 only with the final 0000.
- **Johnson down:** reset, `dir` = 1, one step → `q` = 1000, `phase` = 7, `wrap` = 1. Next step → `q` = 1100, `phase` = 6, `wrap` = 0.
- **Ring up:** `MODE` = 0, reset → `q` = 0001. Four up steps → 0010, 0100, 1000, 0001; `wrap` = 1 only at 0001. Toggling `dir` = 1 at 0100 → next `q` = 0010.
- **Self-correct:** Johnson, `load` 0101 → `illegal` = 1, `phase` = 0. Hold `en` = 0 for 3 cycles → `q` stays 0101. Then `en` = 1 → `q` = 0000, `illegal` = 0, `wrap` = 0.
- **No self-correct:** `SELF_CORRECT` = 0, ring, `load` 0000 → `q` stays 0000 and `illegal` stays 1 across 4 enabled steps. `load` 0110 → next up step gives 1100.
- **Priority and reset:** `load` = 1 and `en` = 1 with `load_val` 0111 → `q` = 0111, `wrap` = 0. Asserting `clear` mid-count between edges → `q` = 0000 and `wrap` = 0 before the next edge.

Source files
------------

// File: rtl/shift_counter_pkg.sv
// rtl/shift_counter_pkg.sv - shared constants and helpers for the shift-register counter
package shift_counter_pkg;

    localparam int MODE_RING    = 0;
    localparam int MODE_JOHNSON = 1;

    // Sequence length: a ring visits WIDTH states, a twisted ring 2*WIDTH.
    function automatic int sc_period(input int width, input int mode);
        return (mode == MODE_JOHNSON) ? 2 * width : width;
    endfunction

endpackage

// File: rtl/shift_phase_decode.sv
// rtl/shift_phase_decode.sv - combinational phase index and legality check of a counter state
module shift_phase_decode
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_JOHNSON
) (
    input  logic [WIDTH-1:0]             q,
    output logic [$clog2(2*WIDTH)-1:0]   phase,
    output logic                         illegal
);

    localparam int PW = $clog2(2 * WIDTH);

    logic [WIDTH-1:0] all_ones;
    assign all_ones = {WIDTH{1'b1}};

    // Compare q against every legal pattern; the matching pattern yields the phase.
    always_comb begin
        logic          legal;
        logic [PW-1:0] ph;
        int            ones;
        legal = 1'b0;
        ph    = '0;
        ones  = 0;
        if (MODE == MODE_JOHNSON) begin
            for (int k = 0; k <= WIDTH; k++) begin
                // k ones anchored at bit 0: early half of the sequence
                if (q == (all_ones >> (WIDTH - k))) begin
                    legal = 1'b1;
                    ph    = PW'(k);
                end
                // k ones anchored at bit WIDTH-1: late half of the sequence
                if ((k > 0) && (k < WIDTH) && (q == ~(all_ones >> k))) begin
                    legal = 1'b1;
                    ph    = PW'(2 * WIDTH - k);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (q[i]) begin
                    ones = ones + 1;
                    ph   = PW'(i);
                end
            end
            legal = (ones == 1);
        end
        illegal = ~legal;
        phase   = legal ? ph : '0;
    end

endmodule

// File: rtl/shift_counter.sv
// rtl/shift_counter.sv - parametrised ring/Johnson counter with load, direction, phase and wrap
module shift_counter
    import shift_counter_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int MODE         = MODE_JOHNSON,
    parameter int SELF_CORRECT = 1
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         en,
    input  logic                         dir,
    input  logic                         load,
    input  logic [WIDTH-1:0]             load_val,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(2*WIDTH)-1:0]   phase,
    output logic                         wrap,
    output logic                         illegal
);

    localparam int               PW      = $clog2(2 * WIDTH);
    localparam int               PERIOD  = sc_period(WIDTH, MODE);
    localparam logic [PW-1:0]    LAST_PH = PW'(PERIOD - 1);
    localparam logic [WIDTH-1:0] RST_VAL = (MODE == MODE_RING) ? WIDTH'(1) : '0;

    logic [WIDTH-1:0] shift_up;
    logic [WIDTH-1:0] shift_dn;
    logic [WIDTH-1:0] next_q;
    logic             next_wrap;

    shift_phase_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_decode (
        .q       (q),
        .phase   (phase),
        .illegal (illegal)
    );

    // Bit entering the vacated end: inverted in Johnson mode, straight in ring mode.
    always_comb begin
        if (MODE == MODE_JOHNSON) begin
            shift_up = {q[WIDTH-2:0], ~q[WIDTH-1]};
            shift_dn = {~q[0], q[WIDTH-1:1]};
        end else begin
            shift_up = {q[WIDTH-2:0], q[WIDTH-1]};
            shift_dn = {q[0], q[WIDTH-1:1]};
        end
    end

    // Next state: load beats enable beats hold; illegal states recover on an enabled step.
    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        if (load) begin
            next_q = load_val;
        end else if (en) begin
            if (illegal && (SELF_CORRECT != 0)) begin
                next_q = RST_VAL;
            end else if (dir) begin
                next_q    = shift_dn;
                next_wrap = ~illegal && (phase == '0);
            end else begin
                next_q    = shift_up;
                next_wrap = ~illegal && (phase == LAST_PH);
            end
        end
    end

    // State and wrap registers, cleared asynchronously.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q    <= RST_VAL;
            wrap <= 1'b0;
        end else begin
            q    <= next_q;
            wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_shift_counter.sv
// tb/tb_shift_counter.sv - directed self-checking bench for shift_counter
module tb_shift_counter;

    logic       clk = 1'b0;
    logic       clear;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] j_q, r_q, n_q;
    logic [2:0] j_phase, r_phase, n_phase;
    logic       j_wrap, r_wrap, n_wrap;
    logic       j_ill, r_ill, n_ill;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    shift_counter #(.WIDTH(4), .MODE(1), .SELF_CORRECT(1)) u_j (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .q(j_q), .phase(j_phase), .wrap(j_wrap), .illegal(j_ill)
    );

    shift_counter #(.WIDTH(4), .MODE(0), .SELF_CORRECT(1)) u_r (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .q(r_q), .phase(r_phase), .wrap(r_wrap), .illegal(r_ill)
    );

    shift_counter #(.WIDTH(4), .MODE(0), .SELF_CORRECT(0)) u_n (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .q(n_q), .phase(n_phase), .wrap(n_wrap), .illegal(n_ill)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        #1;
        clear = 1'b0;
    endtask

    int jq_up [8] = '{1, 3, 7, 15, 14, 12, 8, 0};
    int rq_up [4] = '{2, 4, 8, 1};

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'd0;
        #12;
        check("rst_j_q", j_q, 0);
        check("rst_j_phase", j_phase, 0);
        check("rst_j_ill", j_ill, 0);
        check("rst_j_wrap", j_wrap, 0);
        check("rst_r_q", r_q, 1);
        check("rst_r_ill", r_ill, 0);
        clear = 1'b0;

        // Johnson up over a full period
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("jup_q%0d", i), j_q, jq_up[i]);
            check($sformatf("jup_ph%0d", i), j_phase, (i + 1) % 8);
            check($sformatf("jup_wrap%0d", i), j_wrap, (i == 7) ? 1 : 0);
        end

        // Johnson down from reset
        pulse_clear();
        dir = 1'b1;
        step();
        check("jdn_q0", j_q, 8);
        check("jdn_ph0", j_phase, 7);
        check("jdn_wrap0", j_wrap, 1);
        step();
        check("jdn_q1", j_q, 12);
        check("jdn_ph1", j_phase, 6);
        check("jdn_wrap1", j_wrap, 0);

        // Ring up, then reverse at 0100
        pulse_clear();
        dir = 1'b0;
        check("rup_rst", r_q, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rup_q%0d", i), r_q, rq_up[i]);
            check($sformatf("rup_wrap%0d", i), r_wrap, (i == 3) ? 1 : 0);
        end
        step();
        step();
        check("rdir_at", r_q, 4);
        dir = 1'b1;
        step();
        check("rdir_q", r_q, 2);
        check("rdir_ph", r_phase, 1);

        // Self-correct: illegal Johnson state held while disabled
        pulse_clear();
        en = 1'b0; dir = 1'b0; load = 1'b1; load_val = 4'b0101;
        step();
        load = 1'b0;
        check("sc_load_q", j_q, 5);
        check("sc_load_ill", j_ill, 1);
        check("sc_load_ph", j_phase, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sc_hold%0d", i), j_q, 5);
        end
        en = 1'b1;
        step();
        check("sc_fix_q", j_q, 0);
        check("sc_fix_ill", j_ill, 0);
        check("sc_fix_wrap", j_wrap, 0);

        // No self-correct: ring stuck at zero, illegal pattern still shifts
        en = 1'b0; load = 1'b1; load_val = 4'b0000;
        step();
        load = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("nsc_q%0d", i), n_q, 0);
            check($sformatf("nsc_ill%0d", i), n_ill, 1);
        end
        load = 1'b1; load_val = 4'b0110;
        step();
        load = 1'b0;
        check("nsc_load", n_q, 6);
        step();
        check("nsc_shift", n_q, 12);

        // Load wins over enable
        load = 1'b1; en = 1'b1; load_val = 4'b0111;
        step();
        check("pri_q", j_q, 7);
        check("pri_wrap", j_wrap, 0);

        // Wrap both counters, then clear asynchronously between edges
        load_val = 4'b1000;
        step();
        load = 1'b0;
        step();
        check("pre_clr_jwrap", j_wrap, 1);
        check("pre_clr_rwrap", r_wrap, 1);
        check("pre_clr_rq", r_q, 1);
        step();
        check("pre_clr_rq2", r_q, 2);
        #2;
        clear = 1'b1;
        #1;
        check("clr_rq", r_q, 1);
        check("clr_jq", j_q, 0);
        check("clr_jwrap", j_wrap, 0);
        check("clr_rwrap", r_wrap, 0);
        clear = 1'b0;
        step();
        check("post_clr_jq", j_q, 1);
        check("post_clr_rq", r_q, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
